// File: rtl/usr_seq_pkg.sv
// ----------------------------------------------------------------------------
// usr_seq_pkg
// Shared types for the universal-shift-register command sequencer:
//   - data / shift-count widths and the default command FIFO depth
//   - command opcode encodings (OP_NOP / OP_LOAD / OP_SHL / OP_SHR)
//   - sequencer FSM state enum (S_IDLE / S_LOAD / S_SHIFT / S_DONE)
//   - packed command struct {op, data, count} stored in the command FIFO
//   - clampCount(): limits a requested shift count to the register width
// No ports (package).
// ----------------------------------------------------------------------------
package usr_seq_pkg;

    localparam int WIDTH              = 8;
    localparam int CNT_W              = $clog2(WIDTH + 1);
    localparam int DEFAULT_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_SHL  = 2'b10,
        OP_SHR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] count;
    } cmd_t;

    // Shifting an 8-bit register more than 8 times is meaningless, so any
    // larger request is reduced to a full-width shift.
    function automatic logic [CNT_W-1:0] clampCount(input logic [CNT_W-1:0] count);
        return (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;
    endfunction

endpackage

// File: rtl/usr_seq_cmd_fifo.sv
// ----------------------------------------------------------------------------
// usr_seq_cmd_fifo
// Small synchronous FIFO holding sequencer commands (cmd_t).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset (FIFO empty, not ready)
//   push_i     in   write pushCmd_i (ignored while ready_o is low)
//   pushCmd_i  in   command to enqueue
//   pop_i      in   drop the head entry (ignored while empty_o is high)
//   popCmd_o   out  head entry (valid while empty_o is low)
//   ready_o    out  registered "not full"; low during reset
//   empty_o    out  FIFO holds no entries
// Pointers carry one extra wrap bit so full and empty are distinguishable
// when the index bits are equal.
// ----------------------------------------------------------------------------
module usr_seq_cmd_fifo
    import usr_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  cmd_t pushCmd_i,
    input  logic pop_i,
    output cmd_t popCmd_o,
    output logic ready_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;
    logic        ready_q, ready_d;
    logic        doPush, doPop;
    cmd_t        mem_q [DEPTH];

    // Push is gated by the registered ready, so a full FIFO never accepts a
    // command even if the head is being popped in the same cycle.
    assign doPush   = push_i & ready_q;
    assign doPop    = pop_i & ~empty_o;
    assign empty_o  = (wrPtr_q == rdPtr_q);
    assign ready_o  = ready_q;
    assign popCmd_o = mem_q[rdPtr_q[AW-1:0]];

    // Advance the pointers and precompute whether the FIFO will be full after
    // this edge, so that ready can be presented straight from a flop.
    always_comb begin
        wrPtr_d = wrPtr_q + (AW+1)'(doPush);
        rdPtr_d = rdPtr_q + (AW+1)'(doPop);
        ready_d = !((wrPtr_d[AW] != rdPtr_d[AW]) &&
                    (wrPtr_d[AW-1:0] == rdPtr_d[AW-1:0]));
    end

    // Pointer and ready registers; ready stays low while reset is held and
    // rises on the first clock afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            ready_q <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            ready_q <= ready_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= pushCmd_i;
        end
    end

endmodule

// File: rtl/usr_shift_sequencer.sv
// ----------------------------------------------------------------------------
// usr_shift_sequencer
// Command-driven controller for an 8-bit universal shift register. Accepts
// LOAD / SHL / SHR / NOP commands over valid/ready, queues them in a command
// FIFO and drives one registered USR strobe per clock, pulsing done as each
// command completes.
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   pause          in   (only with USR_SEQ_PAUSE_EN) freeze an active shift
//   cmd_valid      in   command present
//   cmd_ready      out  command FIFO can accept
//   cmd_op         in   00 NOP, 01 LOAD, 10 SHL, 11 SHR
//   cmd_data       in   LOAD value
//   cmd_count      in   number of shifts for SHL/SHR
//   parallel_load  out  USR load strobe
//   shift_left     out  USR shift-left strobe
//   shift_right    out  USR shift-right strobe
//   data_in        out  USR load data, holds the last loaded value
//   busy           out  FSM active or commands queued
//   done           out  one-cycle completion pulse
//   err            out  sticky: a shift count above WIDTH was accepted
// Optional feature macro: USR_SEQ_PAUSE_EN adds the pause input; without it
// the shift strobes of a command are always contiguous.
// ----------------------------------------------------------------------------
module usr_shift_sequencer
    import usr_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
`ifdef USR_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             parallel_load,
    output logic             shift_left,
    output logic             shift_right,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             err
);

    cmd_t             pushCmd, popCmd;
    logic             push, pop, fifoReady, fifoEmpty, pauseActive;
    state_e           state_q, state_d;
    op_e              curOp_q, curOp_d;
    logic [WIDTH-1:0] curData_q, curData_d;
    logic [CNT_W-1:0] shiftCnt_q, shiftCnt_d;
    logic             parallelLoad_q, parallelLoad_d;
    logic             shiftLeft_q, shiftLeft_d;
    logic             shiftRight_q, shiftRight_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] dataIn_q, dataIn_d;
    logic             err_q, err_d;

`ifdef USR_SEQ_PAUSE_EN
    assign pauseActive = pause;
`else
    assign pauseActive = 1'b0;
`endif

    // Oversized counts are clamped before queueing, so the FSM never has to
    // deal with them; err remembers that it happened.
    assign push          = cmd_valid & fifoReady;
    assign pushCmd.op    = op_e'(cmd_op);
    assign pushCmd.data  = cmd_data;
    assign pushCmd.count = clampCount(cmd_count);
    assign err_d         = err_q | (push & (cmd_count > CNT_W'(WIDTH)));

    usr_seq_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmdFifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push),
        .pushCmd_i (pushCmd),
        .pop_i     (pop),
        .popCmd_o  (popCmd),
        .ready_o   (fifoReady),
        .empty_o   (fifoEmpty)
    );

    // State register, working command, shift counter and all output flops.
    // Reset drops every strobe immediately, even mid-command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            curOp_q        <= OP_NOP;
            curData_q      <= '0;
            shiftCnt_q     <= '0;
            parallelLoad_q <= 1'b0;
            shiftLeft_q    <= 1'b0;
            shiftRight_q   <= 1'b0;
            done_q         <= 1'b0;
            dataIn_q       <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            curOp_q        <= curOp_d;
            curData_q      <= curData_d;
            shiftCnt_q     <= shiftCnt_d;
            parallelLoad_q <= parallelLoad_d;
            shiftLeft_q    <= shiftLeft_d;
            shiftRight_q   <= shiftRight_d;
            done_q         <= done_d;
            dataIn_q       <= dataIn_d;
            err_q          <= err_d;
        end
    end

    // Next-state logic. IDLE pops the head command and decodes it; shifts of
    // zero and NOPs go straight to DONE. In SHIFT the counter holds the
    // number of strobes still to issue, and is frozen while paused.
    always_comb begin
        state_d    = state_q;
        curOp_d    = curOp_q;
        curData_d  = curData_q;
        shiftCnt_d = shiftCnt_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    curOp_d   = popCmd.op;
                    curData_d = popCmd.data;
                    case (popCmd.op)
                        OP_LOAD: state_d = S_LOAD;
                        OP_SHL, OP_SHR: begin
                            shiftCnt_d = popCmd.count;
                            state_d    = (popCmd.count != '0) ? S_SHIFT : S_DONE;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_LOAD: state_d = S_DONE;
            S_SHIFT: begin
                if (!pauseActive) begin
                    shiftCnt_d = shiftCnt_q - CNT_W'(1);
                    if (shiftCnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the current state; the results are registered, so
    // each strobe appears one cycle after the FSM enters the matching state.
    // Only one state is active at a time, which keeps the strobes one-hot.
    always_comb begin
        parallelLoad_d = (state_q == S_LOAD);
        shiftLeft_d    = (state_q == S_SHIFT) && !pauseActive && (curOp_q == OP_SHL);
        shiftRight_d   = (state_q == S_SHIFT) && !pauseActive && (curOp_q == OP_SHR);
        done_d         = (state_q == S_DONE);
        dataIn_d       = (state_q == S_LOAD) ? curData_q : dataIn_q;
    end

    assign cmd_ready     = fifoReady;
    assign parallel_load = parallelLoad_q;
    assign shift_left    = shiftLeft_q;
    assign shift_right   = shiftRight_q;
    assign done          = done_q;
    assign data_in       = dataIn_q;
    assign err           = err_q;
    assign busy          = (state_q != S_IDLE) | ~fifoEmpty;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// ----------------------------------------------------------------------------
// tb_usr_shift_sequencer
// Scoreboard bench: every accepted command expands into the sequence of
// output cycles it must produce (strobes then a done pulse); a monitor pops
// one entry for every cycle the DUT shows a strobe or done.
// ----------------------------------------------------------------------------
module tb_usr_shift_sequencer;

    localparam int W = 8;

    typedef enum int {EV_LOAD = 0, EV_SHL = 1, EV_SHR = 2, EV_DONE = 3} evKind_e;

    // follow: 1 = must directly follow an active cycle, 0 = must follow an
    // idle cycle, 2 = either (used while pause can insert gaps)
    typedef struct {
        evKind_e    kind;
        logic [7:0] data;
        int         follow;
    } expEvent_t;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_count;
    logic       parallel_load, shift_left, shift_right;
    logic [7:0] data_in;
    logic       busy, done, err;
`ifdef USR_SEQ_PAUSE_EN
    logic       pause;
`endif

    expEvent_t  sbQueue[$];
    int         checks = 0;
    int         errors = 0;
    logic       errExp = 1'b0;
    logic [7:0] lastLoad = '0;
    logic [7:0] usrModel = '0;
    bit         prevActive = 1'b0;
    bit         readyLowSeen = 1'b0;

    usr_shift_sequencer dut (
        .clk           (clk),
        .reset         (reset),
`ifdef USR_SEQ_PAUSE_EN
        .pause         (pause),
`endif
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .cmd_count     (cmd_count),
        .parallel_load (parallel_load),
        .shift_left    (shift_left),
        .shift_right   (shift_right),
        .data_in       (data_in),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    // Clock starts high so that negedges fall at 5, 15, 25 ns and reset can
    // be released away from a rising edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expand one accepted command into the output cycles it must produce.
    task automatic expectCommand(input int op, input logic [7:0] data,
                                 input int count, input bit paused);
        int n;
        if (count > W) errExp = 1'b1;
        case (op)
            1: begin
                sbQueue.push_back('{EV_LOAD, data, 0});
                sbQueue.push_back('{EV_DONE, 8'h00, 1});
            end
            2, 3: begin
                n = (count > W) ? W : count;
                if (n == 0) begin
                    sbQueue.push_back('{EV_DONE, 8'h00, 0});
                end else begin
                    for (int i = 0; i < n; i++) begin
                        sbQueue.push_back('{(op == 2) ? EV_SHL : EV_SHR, 8'h00,
                                           (i == 0) ? 0 : (paused ? 2 : 1)});
                    end
                    sbQueue.push_back('{EV_DONE, 8'h00, 1});
                end
            end
            default: sbQueue.push_back('{EV_DONE, 8'h00, 0});
        endcase
    endtask

    // Hold the command on the bus until it is accepted (bounded).
    task automatic applyStimulus(input int op, input logic [7:0] data,
                                 input int count, input bit paused);
        bit accepted = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_data  = data;
        cmd_count = 4'(count);
        for (int i = 0; i < 100 && !accepted; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                expectCommand(op, data, count, paused);
                accepted = 1'b1;
                @(negedge clk);
            end else begin
                readyLowSeen = 1'b1;
                @(negedge clk);
            end
        end
        checkOutput("accept_in_time", 32'(accepted), 1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        cmd_valid = 1'b0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((sbQueue.size() != 0 || busy) && n < budget);
        checkOutput("drain_in_time", 32'(sbQueue.size() == 0 && !busy), 1);
    endtask

    // Monitor: one check per active output cycle against the scoreboard, plus
    // the one-hot rule and data_in hold on every cycle. Also keeps a tiny
    // behavioural USR driven by the observed strobes.
    task automatic monitorLoop();
        bit        active;
        evKind_e   seen;
        expEvent_t ev;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevActive = 1'b0;
                continue;
            end
            active = parallel_load | shift_left | shift_right | done;
            checkOutput("onehot0", 32'($onehot0({parallel_load, shift_left, shift_right, done})), 1);
            if (active) begin
                seen = parallel_load ? EV_LOAD : shift_left ? EV_SHL :
                       shift_right ? EV_SHR : EV_DONE;
                checkOutput("expected_output_pending", 32'(sbQueue.size() != 0), 1);
                if (sbQueue.size() != 0) begin
                    ev = sbQueue.pop_front();
                    checkOutput("event_kind", 32'(seen), 32'(ev.kind));
                    if (ev.follow != 2) begin
                        checkOutput("event_contiguity", 32'(prevActive), 32'(ev.follow));
                    end
                    checkOutput("data_in", 32'(data_in),
                                32'((ev.kind == EV_LOAD) ? ev.data : lastLoad));
                    if (ev.kind == EV_LOAD) lastLoad = ev.data;
                end
            end else begin
                checkOutput("data_in_hold", 32'(data_in), 32'(lastLoad));
            end
            if (parallel_load)    usrModel = data_in;
            else if (shift_left)  usrModel = usrModel << 1;
            else if (shift_right) usrModel = usrModel >> 1;
            prevActive = active;
        end
    endtask

    initial begin
        int seen;
        int op;
        int cnt;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        cmd_count = 4'h0;
`ifdef USR_SEQ_PAUSE_EN
        pause     = 1'b0;
`endif
        fork
            monitorLoop();
            begin
                #1000000;
                $display("[TB] FAIL watchdog: simulation did not finish in time");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        // Reset state, then the first rising edge lifts cmd_ready.
        #15 reset = 1'b0;
        #1;
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_strobes", 32'({parallel_load, shift_left, shift_right, done}), 0);
        checkOutput("reset_data_in", 32'(data_in), 0);
        checkOutput("reset_err", 32'(err), 0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", 32'(cmd_ready), 1);
        @(negedge clk);

        $display("[TB] LOAD 8'hAA then SHL 3");
        applyStimulus(1, 8'hAA, 0, 1'b0);
        waitIdle(50);
        checkOutput("usr_after_load", 32'(usrModel), 32'h00AA);
        applyStimulus(2, 8'h00, 3, 1'b0);
        waitIdle(50);
        checkOutput("usr_after_shl3", 32'(usrModel), 32'h0050);

        $display("[TB] back-to-back LOAD 0F, SHR 2, SHR 0, NOP");
        readyLowSeen = 1'b0;
        applyStimulus(1, 8'h0F, 0, 1'b0);
        applyStimulus(3, 8'h00, 2, 1'b0);
        applyStimulus(3, 8'h00, 0, 1'b0);
        applyStimulus(0, 8'h00, 0, 1'b0);
        waitIdle(80);
        checkOutput("ready_dropped_when_full", 32'(readyLowSeen), 1);
        checkOutput("usr_after_shr2", 32'(usrModel), 32'h0003);

        $display("[TB] SHL 12 clamps to 8 and sets err");
        applyStimulus(2, 8'h00, 12, 1'b0);
        waitIdle(60);
        checkOutput("err_after_oversize", 32'(err), 32'(errExp));

        $display("[TB] randomized command stream");
        for (int k = 0; k < 30; k++) begin
            op = int'($urandom_range(0, 3));
            if (op >= 2 && $urandom_range(0, 7) == 0) cnt = int'($urandom_range(9, 15));
            else cnt = int'($urandom_range(0, 8));
            applyStimulus(op, 8'($urandom), cnt, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        waitIdle(400);
        checkOutput("err_sticky", 32'(err), 32'(errExp));

        $display("[TB] reset during SHR 5");
        applyStimulus(3, 8'h00, 5, 1'b0);
        cmd_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 60 && seen < 3; i++) begin
            @(negedge clk);
            if (shift_right) seen++;
        end
        checkOutput("third_shr_strobe_seen", 32'(seen), 3);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_reset_strobes", 32'({parallel_load, shift_left, shift_right, done}), 0);
        checkOutput("mid_reset_busy", 32'(busy), 0);
        checkOutput("mid_reset_err", 32'(err), 0);
        checkOutput("mid_reset_data_in", 32'(data_in), 0);
        checkOutput("mid_reset_cmd_ready", 32'(cmd_ready), 0);
        sbQueue.delete();
        errExp   = 1'b0;
        lastLoad = '0;
        usrModel = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("ready_low_until_clock", 32'(cmd_ready), 0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_second_reset", 32'(cmd_ready), 1);
        repeat (4) @(negedge clk);
        checkOutput("fifo_empty_after_reset", 32'(busy), 0);

`ifdef USR_SEQ_PAUSE_EN
        $display("[TB] SHL 4 with a two-cycle pause");
        applyStimulus(2, 8'h00, 4, 1'b1);
        cmd_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !shift_left; i++) @(negedge clk);
        checkOutput("first_pause_strobe", 32'(shift_left), 1);
        pause = 1'b1;
        repeat (2) @(negedge clk);
        pause = 1'b0;
        seen = 2;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            seen++;
        end
        checkOutput("pause_done_delay", 32'(seen), 6);
        waitIdle(40);
`endif

        applyStimulus(1, 8'h3C, 0, 1'b0);
        applyStimulus(2, 8'h00, 2, 1'b0);
        waitIdle(60);
        checkOutput("usr_final", 32'(usrModel), 32'h00F0);
        checkOutput("err_final", 32'(err), 32'(errExp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
